// File: rtl/sum_accumulator64.sv
// Streaming packet accumulator around the fullAdder64bit ripple adder.
// Optional SUM_ACC_SAT_EN: clamp the running total to all-ones on carry-out.

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module fullAdder64bit (
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic        Cin,
  output logic [63:0] S,
  output logic        Cout
);
  logic [64:0] c;

  assign c[0] = Cin;
  assign Cout = c[64];

  for (genvar i = 0; i < 64; i++) begin : g_bit
    fa_bit u_fa (
      .a   (A[i]),
      .b   (B[i]),
      .cin (c[i]),
      .s   (S[i]),
      .cout(c[i+1])
    );
  end
endmodule

module sum_accumulator64 #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic [CNT_W-1:0] out_ovf_cnt,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t           state;
  logic [63:0]      acc;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] ovf;
  logic [63:0]      add_s;
  logic             add_cout;
  logic [63:0]      acc_nxt;
  logic             accept;

  fullAdder64bit u_add (
    .A   (acc),
    .B   (in_data),
    .Cin (1'b0),
    .S   (add_s),
    .Cout(add_cout)
  );

`ifdef SUM_ACC_SAT_EN
  // Once all-ones, any further beat either carries or adds zero, so it sticks.
  assign acc_nxt = add_cout ? {64{1'b1}} : add_s;
`else
  assign acc_nxt = add_s;
`endif

  assign accept = in_valid && in_ready;

  // Handshake flags are kept as registers alongside state so no input reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc <= acc_nxt;
            if (count != {CNT_W{1'b1}}) count <= count + CNT_W'(1);
            if (add_cout && (ovf != {CNT_W{1'b1}})) ovf <= ovf + CNT_W'(1);
            if (in_last) begin
              state     <= DONE;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              busy      <= 1'b0;
            end else begin
              state <= ACC;
              busy  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_sum     = acc;
  assign out_count   = count;
  assign out_ovf_cnt = ovf;
endmodule

// File: tb/tb_sum_accumulator64.sv
// Directed bench for sum_accumulator64; expectations are hand-computed constants.
// Build with +define+SUM_ACC_SAT_EN to exercise the saturating variant.

module tb_sum_accumulator64;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  logic [CNT_W-1:0] out_ovf_cnt;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_accumulator64 #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .out_count  (out_count),
    .out_ovf_cnt(out_ovf_cnt),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [63:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
  endtask

  logic [63:0] exp_wrap_sum;

  initial begin
`ifdef SUM_ACC_SAT_EN
    exp_wrap_sum = 64'hFFFF_FFFF_FFFF_FFFF;
`else
    exp_wrap_sum = 64'd1;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", out_sum, 64'd0);
    chk("rst_count", 64'(out_count), 64'd0);
    chk("rst_ovf", 64'(out_ovf_cnt), 64'd0);

    // Single-beat packet
    beat(64'd10000, 1'b1);
    chk("single_valid", 64'(out_valid), 64'd1);
    chk("single_sum", out_sum, 64'd10000);
    chk("single_count", 64'(out_count), 64'd1);
    chk("single_ovf", 64'(out_ovf_cnt), 64'd0);
    chk("single_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("single_after_ready", 64'(in_ready), 64'd1);
    chk("single_after_valid", 64'(out_valid), 64'd0);
    chk("single_after_sum", out_sum, 64'd0);

    // Two beats back-to-back
    in_valid = 1'b1; in_data = 64'd10000; in_last = 1'b0;
    step();
    chk("two_busy", 64'(busy), 64'd1);
    chk("two_partial", out_sum, 64'd10000);
    in_data = 64'd20000; in_last = 1'b1;
    step();
    in_valid = 1'b0;
    chk("two_valid", 64'(out_valid), 64'd1);
    chk("two_sum", out_sum, 64'd30000);
    chk("two_count", 64'(out_count), 64'd2);
    chk("two_busy_done", 64'(busy), 64'd0);
    step();

    // Carry-out beat
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    beat(64'd2, 1'b1);
    chk("ovf_sum", out_sum, exp_wrap_sum);
    chk("ovf_cnt", 64'(out_ovf_cnt), 64'd1);
    chk("ovf_count", 64'(out_count), 64'd2);
    step();

    // Backpressure on the result while the next beat waits
    out_ready = 1'b0;
    beat(64'd3, 1'b1);
    in_valid = 1'b1; in_data = 64'd99; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_sum", out_sum, 64'd3);
      chk("bp_count", 64'(out_count), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_release_sum", out_sum, 64'd0);
    step();
    in_valid = 1'b0;
    chk("bp_99_valid", 64'(out_valid), 64'd1);
    chk("bp_99_sum", out_sum, 64'd99);
    chk("bp_99_count", 64'(out_count), 64'd1);
    step();

    // Asynchronous reset mid-packet
    beat(64'd5, 1'b0);
    beat(64'd6, 1'b0);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_sum", out_sum, 64'd11);
    chk("mid_count", 64'(out_count), 64'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_sum", out_sum, 64'd0);
    chk("arst_count", 64'(out_count), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd1);
    chk("arst_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    beat(64'd7, 1'b1);
    chk("post_valid", 64'(out_valid), 64'd1);
    chk("post_sum", out_sum, 64'd7);
    chk("post_count", 64'(out_count), 64'd1);
    chk("post_ovf", 64'(out_ovf_cnt), 64'd0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
